// File: rtl/lattice_pkg.sv
// Shared widths and fixed-point helpers for the lattice filter bank.
// Helpers work at CALC_W bits so callers of any sample/coefficient width can share them.
package lattice_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_STAGES = 4;
    localparam int DEF_AW     = 4;
    localparam int CALC_W     = 64;

    // Clip a signed value to the range of a width-bit two's complement word.
    function automatic logic signed [CALC_W-1:0] sat_trunc(
        input logic signed [CALC_W-1:0] value,
        input int                       width
    );
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = (CALC_W'(1) <<< (width - 1)) - CALC_W'(1);
        lo = -hi - CALC_W'(1);
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    // Round half up, then drop frac fractional bits (arithmetic shift).
    function automatic logic signed [CALC_W-1:0] round_shift(
        input logic signed [CALC_W-1:0] value,
        input int                       frac
    );
        return (value + (CALC_W'(1) <<< (frac - 1))) >>> frac;
    endfunction

endpackage

// File: rtl/lattice_stage.sv
// One FIR lattice stage: delay register on the backward path, two
// multiply-round-add-saturate paths, registered f/g/valid outputs.
module lattice_stage
    import lattice_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] f_up,
    input  logic signed [DATA_W-1:0] g_up,
    input  logic                     vld_up,
    input  logic signed [COEF_W-1:0] k,
    output logic signed [DATA_W-1:0] f_dn,
    output logic signed [DATA_W-1:0] g_dn,
    output logic                     vld_dn
);

    localparam int PW = DATA_W + COEF_W;
    localparam int SW = DATA_W + 2;

    logic signed [DATA_W-1:0] g_dly;
    logic signed [PW-1:0]     prod_f_p0;
    logic signed [PW-1:0]     prod_g_p0;
    logic signed [SW-1:0]     sum_f_p0;
    logic signed [SW-1:0]     sum_g_p0;
    logic signed [DATA_W-1:0] f_nxt_p0;
    logic signed [DATA_W-1:0] g_nxt_p0;
    logic signed [DATA_W-1:0] f_p1;
    logic signed [DATA_W-1:0] g_p1;
    logic                     vld_p1;

    // p0: combinational arithmetic on the stage inputs and the delayed g
    always_comb begin
        prod_f_p0 = PW'(k) * PW'(g_dly);
        prod_g_p0 = PW'(k) * PW'(f_up);
        sum_f_p0  = SW'(f_up) + SW'(round_shift(CALC_W'(prod_f_p0), COEF_W - 1));
        sum_g_p0  = SW'(round_shift(CALC_W'(prod_g_p0), COEF_W - 1)) + SW'(g_dly);
        f_nxt_p0  = DATA_W'(sat_trunc(CALC_W'(sum_f_p0), DATA_W));
        g_nxt_p0  = DATA_W'(sat_trunc(CALC_W'(sum_g_p0), DATA_W));
    end

    // p1: registered outputs; filter state only moves on valid samples
    always_ff @(posedge clk) begin
        if (clr) begin
            g_dly  <= '0;
            f_p1   <= '0;
            g_p1   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_up;
            if (vld_up) begin
                g_dly <= g_up;
                f_p1  <= f_nxt_p0;
                g_p1  <= g_nxt_p0;
            end
        end
    end

    assign f_dn   = f_p1;
    assign g_dn   = g_p1;
    assign vld_dn = vld_p1;

endmodule

// File: rtl/lattice_filter_bank.sv
// Cascade of STAGES lattice stages with a run-time coefficient register file.
// Emits forward and backward outputs of the last stage, STAGES cycles after input.
module lattice_filter_bank
    import lattice_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int STAGES = DEF_STAGES,
    parameter int AW     = DEF_AW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic                     x_valid,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     state_clr,
    output logic signed [DATA_W-1:0] y_f,
    output logic signed [DATA_W-1:0] y_g,
    output logic                     y_valid
);

    logic signed [COEF_W-1:0] coef [STAGES];
    logic signed [DATA_W-1:0] f_chain [STAGES+1];
    logic signed [DATA_W-1:0] g_chain [STAGES+1];
    logic                     vld_chain [STAGES+1];
    logic                     clr;

    // Both reset and state_clr flush delays and valids; only reset touches coefficients.
    assign clr          = reset | state_clr;
    assign f_chain[0]   = x_in;
    assign g_chain[0]   = x_in;
    assign vld_chain[0] = x_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                coef[i] <= '0;
            end
        end else if (coef_we) begin
            for (int i = 0; i < STAGES; i++) begin
                if (int'(coef_addr) == i) begin
                    coef[i] <= coef_data;
                end
            end
        end
    end

    for (genvar m = 0; m < STAGES; m++) begin : g_stage
        lattice_stage #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W)
        ) u_stage (
            .clk    (clk),
            .clr    (clr),
            .f_up   (f_chain[m]),
            .g_up   (g_chain[m]),
            .vld_up (vld_chain[m]),
            .k      (coef[m]),
            .f_dn   (f_chain[m+1]),
            .g_dn   (g_chain[m+1]),
            .vld_dn (vld_chain[m+1])
        );
    end

    assign y_f     = f_chain[STAGES];
    assign y_g     = g_chain[STAGES];
    assign y_valid = vld_chain[STAGES];

endmodule
